sr_mc_control: RTL

Multicycle control unit for the schoolRISCV datapath: the producer side of the ALU interface. It decodes the instruction register fields, sequences each instruction through a registered state machine, and drives the ALU operation code and operand selects. It consumes the ALU `zero`/`slt` flags to resolve branches and handshakes with a single shared instruction/data memory port. It replaces the single-cycle combinational control when the CPU is built in multicycle mode.

---
 rtl/sr_mc_control_pkg.sv | 60 ++++++
 rtl/sr_mc_alu_dec.sv | 59 +++++
 rtl/sr_mc_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sr_mc_control_pkg.sv
// Shared encodings for the multicycle schoolRISCV control unit: ALU codes,
// RISC-V opcode/funct fields, datapath select values and the FSM state type.
package sr_mc_control_pkg;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SRL  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;

   localparam logic [6:0] RVOP_OP     = 7'b0110011;
   localparam logic [6:0] RVOP_OPIMM  = 7'b0010011;
   localparam logic [6:0] RVOP_LOAD   = 7'b0000011;
   localparam logic [6:0] RVOP_STORE  = 7'b0100011;
   localparam logic [6:0] RVOP_BRANCH = 7'b1100011;
   localparam logic [6:0] RVOP_LUI    = 7'b0110111;

   localparam logic [2:0] RVF3_ADD  = 3'b000;
   localparam logic [2:0] RVF3_OR   = 3'b110;
   localparam logic [2:0] RVF3_SRL  = 3'b101;
   localparam logic [2:0] RVF3_SLTU = 3'b011;
   localparam logic [2:0] RVF3_SLT  = 3'b010;
   localparam logic [2:0] RVF3_BEQ  = 3'b000;
   localparam logic [2:0] RVF3_BNE  = 3'b001;
   localparam logic [2:0] RVF3_BLT  = 3'b100;
   localparam logic [2:0] RVF3_BGE  = 3'b101;

   localparam logic [6:0] RVF7_ZERO = 7'b0000000;
   localparam logic [6:0] RVF7_SUB  = 7'b0100000;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_BRANCH,
      S_LUI,
      S_TRAP
   } state_t;

endpackage

// File: rtl/sr_mc_alu_dec.sv
// Instruction-field to ALU-operation decoder with a legality flag; used both
// when deciding the decode-stage trap and when driving EXEC/BRANCH ALU codes.
module sr_mc_alu_dec
   import sr_mc_control_pkg::*;
(
   input  logic [6:0] cmd_op,
   input  logic [2:0] cmd_f3,
   input  logic [6:0] cmd_f7,
   output logic [2:0] alu_control,
   output logic       legal
);

   always_comb begin
      alu_control = ALU_ADD;
      legal       = 1'b1;
      case (cmd_op)
         RVOP_OP: begin
            case (cmd_f3)
               RVF3_ADD: begin
                  if (cmd_f7 == RVF7_ZERO)     alu_control = ALU_SUB ^ ALU_SUB;
                  else if (cmd_f7 == RVF7_SUB) alu_control = ALU_SUB;
                  else                         legal       = 1'b0;
               end
               RVF3_OR:   alu_control = ALU_OR;
               RVF3_SRL: begin
                  if (cmd_f7 == RVF7_ZERO) alu_control = ALU_SRL;
                  else                     legal       = 1'b0;
               end
               RVF3_SLTU: alu_control = ALU_SLTU;
               RVF3_SLT:  alu_control = ALU_SLT;
               default:   legal       = 1'b0;
            endcase
         end
         RVOP_OPIMM: begin
            case (cmd_f3)
               RVF3_ADD:  alu_control = ALU_ADD;
               RVF3_OR:   alu_control = ALU_OR;
               RVF3_SLTU: alu_control = ALU_SLTU;
               RVF3_SLT:  alu_control = ALU_SLT;
               RVF3_SRL: begin
                  if (cmd_f7 == RVF7_ZERO) alu_control = ALU_SRL;
                  else                     legal       = 1'b0;
               end
               default:   legal       = 1'b0;
            endcase
         end
         RVOP_BRANCH: begin
            case (cmd_f3)
               RVF3_BEQ, RVF3_BNE: alu_control = ALU_SUB;
               RVF3_BLT, RVF3_BGE: alu_control = ALU_SLT;
               default:            legal       = 1'b0;
            endcase
         end
         RVOP_LOAD, RVOP_STORE, RVOP_LUI: alu_control = ALU_ADD;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/sr_mc_control.sv
// Multicycle schoolRISCV control FSM. Memory handshake: memReq with its
// adrSrc/memWe selects is held until the cycle memReady=1, which completes
// exactly one transfer; memReady outside a request state is ignored.
module sr_mc_control
   import sr_mc_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] cmdOp,
   input  logic [2:0] cmdF3,
   input  logic [6:0] cmdF7,
   input  logic       aluZero,
   input  logic       aluSlt,
   input  logic       memReady,
   output logic       memReq,
   output logic       memWe,
   output logic       adrSrc,
   output logic       irWrite,
   output logic       pcWrite,
   output logic       regWrite,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] resultSrc,
   output logic [2:0] aluControl,
   output logic       illegal,
   output logic       instrDone
);

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [2:0] dec_alu;
   logic       dec_legal;
   logic       br_taken;

   sr_mc_alu_dec u_alu_dec (
      .cmd_op      (cmdOp),
      .cmd_f3      (cmdF3),
      .cmd_f7      (cmdF7),
      .alu_control (dec_alu),
      .legal       (dec_legal)
   );

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      br_taken   = 1'b0;
      memReq     = 1'b0;
      memWe      = 1'b0;
      adrSrc     = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      regWrite   = 1'b0;
      instrDone  = 1'b0;
      aluSrcA    = SRCA_PC;
      aluSrcB    = SRCB_RS2;
      resultSrc  = RES_ALUOUT;
      aluControl = ALU_ADD;

      case (state_q)
         S_FETCH: begin
            memReq    = 1'b1;
            aluSrcB   = SRCB_FOUR;
            resultSrc = RES_ALU;
            if (memReady) begin
               irWrite = 1'b1;
               pcWrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            aluSrcA = SRCA_OLDPC;
            aluSrcB = SRCB_IMM;
            if (!dec_legal) state_d = S_TRAP;
            else begin
               case (cmdOp)
                  RVOP_OP:                state_d = S_EXEC_R;
                  RVOP_OPIMM:             state_d = S_EXEC_I;
                  RVOP_LOAD, RVOP_STORE:  state_d = S_MEMADR;
                  RVOP_BRANCH:            state_d = S_BRANCH;
                  RVOP_LUI:               state_d = S_LUI;
                  default:                state_d = S_TRAP;
               endcase
            end
         end
         S_EXEC_R: begin
            aluSrcA    = SRCA_RS1;
            aluSrcB    = SRCB_RS2;
            aluControl = dec_alu;
            state_d    = S_ALUWB;
         end
         S_EXEC_I: begin
            aluSrcA    = SRCA_RS1;
            aluSrcB    = SRCB_IMM;
            aluControl = dec_alu;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            resultSrc = RES_ALUOUT;
            regWrite  = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMADR: begin
            aluSrcA = SRCA_RS1;
            aluSrcB = SRCB_IMM;
            state_d = (cmdOp == RVOP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            memReq = 1'b1;
            adrSrc = 1'b1;
            if (memReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultSrc = RES_MEM;
            regWrite  = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            memReq = 1'b1;
            memWe  = 1'b1;
            adrSrc = 1'b1;
            if (memReady) begin
               instrDone = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_BRANCH: begin
            aluSrcA    = SRCA_RS1;
            aluSrcB    = SRCB_RS2;
            resultSrc  = RES_ALUOUT;
            aluControl = dec_alu;
            // f3[2] picks the flag, f3[0] inverts the sense (BNE/BGE)
            br_taken   = (cmdF3[2] ? aluSlt : aluZero) ^ cmdF3[0];
            pcWrite    = br_taken;
            instrDone  = 1'b1;
            state_d    = S_FETCH;
         end
         S_LUI: begin
            resultSrc = RES_IMM;
            regWrite  = 1'b1;
            instrDone = 1'b1;
            state_d   = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase

      if (state_d == S_TRAP) illegal_d = 1'b1;

      // Reset is asynchronous, so the strobes must drop in the same cycle.
      if (rst) begin
         memReq     = 1'b0;
         memWe      = 1'b0;
         adrSrc     = 1'b0;
         irWrite    = 1'b0;
         pcWrite    = 1'b0;
         regWrite   = 1'b0;
         instrDone  = 1'b0;
         aluSrcA    = SRCA_PC;
         aluSrcB    = SRCB_RS2;
         resultSrc  = RES_ALUOUT;
         aluControl = ALU_ADD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   assign illegal = illegal_q;

endmodule
